// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the rr_mux_arb valid/ready N:1 arbitrating multiplexer.
package rr_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    // Width of a channel index; a single channel still gets a 1-bit index.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arb_core.sv
// Combinational arbiter: picks one requester either lowest-index-first or
// round-robin starting at ptr, returning a one-hot grant and its encoded index.
module rr_arb_core
    import rr_mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = sel_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic              mode,
    input  logic [SEL_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [SEL_W-1:0]  grant_idx,
    output logic              grant_vld
);

    int start;
    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        start     = 0;
        idx       = 0;

        // Fixed priority is simply a round-robin search anchored at channel 0.
        if (mode_e'(mode) == MODE_RR && int'(ptr) < NUM_CH) begin
            start = int'(ptr);
        end

        for (int k = 0; k < NUM_CH; k++) begin
            idx = start + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!grant_vld && req[idx]) begin
                grant_vld  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_mux_arb.sv
// N:1 valid/ready arbitrating mux with a registered output slot (latency 1, 1 beat/cycle).
// Optional packet locking on in_last/out_last is enabled by defining RR_MUX_LOCK_EN.
module rr_mux_arb
    import rr_mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = sel_width(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
`ifdef RR_MUX_LOCK_EN
    input  logic [NUM_CH-1:0]        in_last,
    output logic                     out_last,
`endif
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_sel,
    input  logic                     out_ready
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0]  out_sel_q,   out_sel_d;
    logic [SEL_W-1:0]  ptr_q,       ptr_d;

    logic              slot_free;
    logic              accept;
    logic              pkt_end;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] grant;
    logic [SEL_W-1:0]  grant_idx;
    logic              grant_vld;
    logic [DATA_W-1:0] sel_data;
    int                ptr_nxt;

`ifdef RR_MUX_LOCK_EN
    logic              lock_q,     lock_d;
    logic [SEL_W-1:0]  lock_ch_q,  lock_ch_d;
    logic              out_last_q, out_last_d;
    logic [NUM_CH-1:0] lock_mask;
`endif

    // While a packet is open only the owning channel may compete.
    always_comb begin
        req = in_valid;
`ifdef RR_MUX_LOCK_EN
        lock_mask = '0;
        lock_mask[lock_ch_q] = 1'b1;
        if (lock_q) begin
            req = in_valid & lock_mask;
        end
`endif
    end

    rr_arb_core #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_arb_core (
        .req       (req),
        .mode      (mode),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    always_comb begin
        slot_free = !out_valid_q || out_ready;
        // Gating with rst_n keeps producers from seeing a grant during reset.
        in_ready  = (rst_n && slot_free) ? grant : '0;
        accept    = slot_free && grant_vld;
        sel_data  = in_data[int'(grant_idx)*DATA_W +: DATA_W];

        ptr_nxt = int'(grant_idx) + 1;
        if (ptr_nxt >= NUM_CH) begin
            ptr_nxt = 0;
        end

`ifdef RR_MUX_LOCK_EN
        pkt_end = in_last[grant_idx];
`else
        pkt_end = 1'b1;
`endif
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
`ifdef RR_MUX_LOCK_EN
        lock_d      = lock_q;
        lock_ch_d   = lock_ch_q;
        out_last_d  = out_last_q;
`endif

        // Drain and reload share one cycle, so a free slot always takes the new beat.
        if (slot_free) begin
            out_valid_d = accept;
        end

        if (accept) begin
            out_data_d = sel_data;
            out_sel_d  = grant_idx;
`ifdef RR_MUX_LOCK_EN
            out_last_d = in_last[grant_idx];
            lock_d     = !in_last[grant_idx];
            lock_ch_d  = grant_idx;
`endif
            if (mode_e'(mode) == MODE_RR && pkt_end) begin
                ptr_d = SEL_W'(ptr_nxt);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

`ifdef RR_MUX_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q     <= 1'b0;
            lock_ch_q  <= '0;
            out_last_q <= 1'b0;
        end else begin
            lock_q     <= lock_d;
            lock_ch_q  <= lock_ch_d;
            out_last_q <= out_last_d;
        end
    end

    assign out_last = out_last_q;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed bench for rr_mux_arb; inputs change and outputs are sampled on the falling clock edge.
module tb_rr_mux_arb;

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_ready;
`ifdef RR_MUX_LOCK_EN
    logic [3:0]  in_last;
    logic        out_last;
`endif

    int n_checks = 0;
    int n_errors = 0;

    rr_mux_arb #(
        .NUM_CH (4),
        .DATA_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
`ifdef RR_MUX_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        repeat (2) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
            n_checks++; if (in_ready !== 4'b0000) begin n_errors++; $display("FAIL rst_in_ready: got %b want 0000", in_ready); end
        end
        n_checks++; if (out_data !== 8'h00 || out_sel !== 2'd0) begin n_errors++; $display("FAIL rst_slot: got data %h sel %0d want 00/0", out_data, out_sel); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (in_ready !== 4'b0001) begin n_errors++; $display("FAIL rel_in_ready: got %b want 0001", in_ready); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 8'hA0) begin
            n_errors++; $display("FAIL rel_first_beat: got v%b sel %0d data %h want v1 sel 0 data a0", out_valid, out_sel, out_data);
        end
    endtask

    task automatic test_fixed_priority();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if (out_sel !== 2'd0 || out_valid !== 1'b1) begin n_errors++; $display("FAIL fixed_sel[%0d]: got v%b sel %0d want v1 sel 0", i, out_valid, out_sel); end
            n_checks++; if (in_ready !== 4'b0001) begin n_errors++; $display("FAIL fixed_grant[%0d]: got %b want 0001", i, in_ready); end
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_sel [5];
        logic [7:0] exp_data;
        exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        mode = 1'b1;
        #1;
        n_checks++; if (in_ready !== 4'b0001) begin n_errors++; $display("FAIL rr_start_grant: got %b want 0001", in_ready); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            exp_data = in_data[int'(exp_sel[i])*8 +: 8];
            n_checks++; if (out_valid !== 1'b1 || out_sel !== exp_sel[i] || out_data !== exp_data) begin
                n_errors++; $display("FAIL rr_seq[%0d]: got v%b sel %0d data %h want v1 sel %0d data %h", i, out_valid, out_sel, out_data, exp_sel[i], exp_data);
            end
        end
        in_valid = 4'b0100;
    endtask

    task automatic test_rr_wrap();
        logic [1:0] exp_sel [4];
        exp_sel = '{2'd3, 2'd2, 2'd3, 2'd2};
        @(negedge clk);
        n_checks++; if (out_sel !== 2'd2) begin n_errors++; $display("FAIL wrap_setup: got sel %0d want 2", out_sel); end
        in_valid = 4'b1100;
        #1;
        n_checks++; if (in_ready !== 4'b1000) begin n_errors++; $display("FAIL wrap_grant: got %b want 1000", in_ready); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b1 || out_sel !== exp_sel[i]) begin
                n_errors++; $display("FAIL wrap_seq[%0d]: got v%b sel %0d want v1 sel %0d", i, out_valid, out_sel, exp_sel[i]);
            end
        end
    endtask

    task automatic test_stall();
        in_data[15:8] = 8'hA5;
        in_valid = 4'b0010;
        #1;
        n_checks++; if (in_ready !== 4'b0010) begin n_errors++; $display("FAIL stall_setup_grant: got %b want 0010", in_ready); end
        @(negedge clk);
        n_checks++; if (out_sel !== 2'd1 || out_data !== 8'hA5) begin n_errors++; $display("FAIL stall_load: got sel %0d data %h want 1/a5", out_sel, out_data); end
        out_ready = 1'b0;
        in_valid = 4'b1111;
        in_data[15:8] = 8'h5A;
        #1;
        n_checks++; if (in_ready !== 4'b0000) begin n_errors++; $display("FAIL stall_no_grant: got %b want 0000", in_ready); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 8'hA5) begin
                n_errors++; $display("FAIL stall_hold[%0d]: got v%b sel %0d data %h want v1 sel 1 data a5", i, out_valid, out_sel, out_data);
            end
            n_checks++; if (in_ready !== 4'b0000) begin n_errors++; $display("FAIL stall_ready[%0d]: got %b want 0000", i, in_ready); end
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 4'b0100) begin n_errors++; $display("FAIL stall_release_grant: got %b want 0100", in_ready); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 8'hC2) begin
            n_errors++; $display("FAIL stall_release_beat: got v%b sel %0d data %h want v1 sel 2 data c2", out_valid, out_sel, out_data);
        end
    endtask

    task automatic test_idle_and_mode();
        in_valid = 4'b0000;
        #1;
        n_checks++; if (in_ready !== 4'b0000) begin n_errors++; $display("FAIL idle_ready: got %b want 0000", in_ready); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL idle_drain: got out_valid %b want 0", out_valid); end
        in_valid = 4'b1111;
        #1;
        n_checks++; if (in_ready !== 4'b1000) begin n_errors++; $display("FAIL idle_ptr_kept: got %b want 1000", in_ready); end
        mode = 1'b0;
        #1;
        n_checks++; if (in_ready !== 4'b0001) begin n_errors++; $display("FAIL mode_to_fixed: got %b want 0001", in_ready); end
        mode = 1'b1;
        #1;
        n_checks++; if (in_ready !== 4'b1000) begin n_errors++; $display("FAIL mode_ptr_kept: got %b want 1000", in_ready); end
        in_valid = 4'b0100;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_sel !== 2'd2) begin n_errors++; $display("FAIL ares_setup: got v%b sel %0d want v1 sel 2", out_valid, out_sel); end
        in_valid = 4'b1111;
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || out_sel !== 2'd0 || out_data !== 8'h00) begin
            n_errors++; $display("FAIL ares_clear: got v%b sel %0d data %h want v0 sel 0 data 00", out_valid, out_sel, out_data);
        end
        n_checks++; if (in_ready !== 4'b0000) begin n_errors++; $display("FAIL ares_ready: got %b want 0000", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (in_ready !== 4'b0001) begin n_errors++; $display("FAIL ares_ptr_reset: got %b want 0001", in_ready); end
    endtask

`ifdef RR_MUX_LOCK_EN
    task automatic test_lock();
        in_valid = 4'b0011;
        in_last = 4'b0000;
        in_data[7:0] = 8'h01;
        #1;
        n_checks++; if (in_ready !== 4'b0001) begin n_errors++; $display("FAIL lock_first_grant: got %b want 0001", in_ready); end
        @(negedge clk);
        n_checks++; if (out_sel !== 2'd0 || out_last !== 1'b0 || out_data !== 8'h01) begin
            n_errors++; $display("FAIL lock_beat1: got sel %0d last %b data %h want 0/0/01", out_sel, out_last, out_data);
        end
        in_valid = 4'b0010;
        #1;
        n_checks++; if (in_ready !== 4'b0000) begin n_errors++; $display("FAIL lock_ignore_other: got %b want 0000", in_ready); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL lock_bubble: got out_valid %b want 0", out_valid); end
        in_valid = 4'b0011;
        in_data[7:0] = 8'h02;
        #1;
        n_checks++; if (in_ready !== 4'b0001) begin n_errors++; $display("FAIL lock_resume: got %b want 0001", in_ready); end
        @(negedge clk);
        n_checks++; if (out_sel !== 2'd0 || out_last !== 1'b0 || out_data !== 8'h02) begin
            n_errors++; $display("FAIL lock_beat2: got sel %0d last %b data %h want 0/0/02", out_sel, out_last, out_data);
        end
        in_data[7:0] = 8'h03;
        in_last = 4'b0001;
        @(negedge clk);
        n_checks++; if (out_sel !== 2'd0 || out_last !== 1'b1 || out_data !== 8'h03) begin
            n_errors++; $display("FAIL lock_beat3: got sel %0d last %b data %h want 0/1/03", out_sel, out_last, out_data);
        end
        in_last = 4'b0000;
        #1;
        n_checks++; if (in_ready !== 4'b0010) begin n_errors++; $display("FAIL lock_release_grant: got %b want 0010", in_ready); end
        @(negedge clk);
        n_checks++; if (out_sel !== 2'd1 || out_last !== 1'b0) begin
            n_errors++; $display("FAIL lock_next_ch: got sel %0d last %b want 1/0", out_sel, out_last);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        mode = 1'b0;
        in_valid = 4'b1111;
        in_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        out_ready = 1'b1;
`ifdef RR_MUX_LOCK_EN
        in_last = 4'b0000;
`endif
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_rr_wrap();
        test_stall();
        test_idle_and_mode();
        test_async_reset();
`ifdef RR_MUX_LOCK_EN
        test_lock();
`endif
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
